// File: rtl/calc_accumulator_core.sv
// Accumulator datapath for the calculator: eight Enter-triggered operations on NumOut,
// including a shift-add multiply that takes several cycles and an UNDO history of previous accumulator values.
module calc_accumulator_core #(
    parameter int WIDTH      = 8,
    parameter int HIST_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic [WIDTH-1:0]              NumIn,
    input  logic [2:0]                    OpIn,
    input  logic                          Enter,
    output logic [WIDTH-1:0]              NumOut,
    output logic                          Carry,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Err,
    output logic [$clog2(HIST_DEPTH):0]   HistCount
);

    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(HIST_DEPTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_EQ   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_UNDO = 3'd7;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state_reg, state_next;
    logic                   enter_q;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;
    logic [2*WIDTH-1:0]     prod_reg;
    logic [IW-1:0]          iter_reg;
    logic [PW-1:0]          wr_ptr_reg;
    logic [WIDTH-1:0]       hist_mem [HIST_DEPTH];

    logic [WIDTH-1:0]       num_next;
    logic                   carry_next, done_next, err_next;
    logic                   accept, mul_last, hist_empty, push, pop;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     prod_sum;
    logic [PW-1:0]          ptr_inc, ptr_dec;

    assign accept     = Enter & ~enter_q & (state_reg == IDLE);
    assign sum        = {1'b0, NumOut} + {1'b0, NumIn};
    assign prod_sum   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_last   = (state_reg == MUL) && (iter_reg == IW'(WIDTH - 1));
    assign hist_empty = (HistCount == '0);
    // MUL records its old A only when it finishes, so an aborted multiply leaves no trace.
    assign push       = (accept && OpIn != OP_UNDO && OpIn != OP_MUL) || mul_last;
    assign pop        = accept && OpIn == OP_UNDO && !hist_empty;
    assign ptr_inc    = (wr_ptr_reg == PW'(HIST_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign ptr_dec    = (wr_ptr_reg == '0) ? PW'(HIST_DEPTH - 1) : wr_ptr_reg - 1'b1;
    assign Busy       = (state_reg == MUL);

    always_comb begin
        state_next = state_reg;
        num_next   = NumOut;
        carry_next = Carry;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    done_next = 1'b1;
                    case (OpIn)
                        OP_ADD: {carry_next, num_next} = sum;
                        OP_SUB: begin
                            num_next   = NumOut - NumIn;
                            carry_next = (NumIn > NumOut);
                        end
                        OP_OR: begin
                            num_next   = NumOut | NumIn;
                            carry_next = 1'b0;
                        end
                        OP_EQ: begin
                            num_next   = (NumOut == NumIn) ? WIDTH'(1) : '0;
                            carry_next = 1'b0;
                        end
                        OP_AND: begin
                            num_next   = NumOut & NumIn;
                            carry_next = 1'b0;
                        end
                        OP_XOR: begin
                            num_next   = NumOut ^ NumIn;
                            carry_next = 1'b0;
                        end
                        OP_MUL: begin
                            state_next = MUL;
                            done_next  = 1'b0;
                        end
                        default: begin
                            if (hist_empty) begin
                                err_next  = 1'b1;
                                done_next = 1'b0;
                            end else begin
                                num_next   = hist_mem[ptr_dec];
                                carry_next = 1'b0;
                            end
                        end
                    endcase
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = IDLE;
                    num_next   = prod_sum[WIDTH-1:0];
                    carry_next = |prod_sum[2*WIDTH-1:WIDTH];
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            enter_q   <= 1'b1;
            NumOut    <= '0;
            Carry     <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state_reg <= state_next;
            enter_q   <= Enter;
            NumOut    <= num_next;
            Carry     <= carry_next;
            Done      <= done_next;
            Err       <= err_next;
        end
    end

    // Multiplier: A is consumed LSB first while B shifts left into the 2*WIDTH product.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            iter_reg   <= '0;
        end else if (accept && OpIn == OP_MUL) begin
            mcand_reg  <= {{WIDTH{1'b0}}, NumIn};
            mplier_reg <= NumOut;
            prod_reg   <= '0;
            iter_reg   <= '0;
        end else if (state_reg == MUL) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            prod_reg   <= prod_sum;
            iter_reg   <= iter_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            HistCount  <= '0;
        end else if (push) begin
            wr_ptr_reg <= ptr_inc;
            if (HistCount != CW'(HIST_DEPTH))
                HistCount <= HistCount + 1'b1;
        end else if (pop) begin
            wr_ptr_reg <= ptr_dec;
            HistCount  <= HistCount - 1'b1;
        end
    end

    // Entry contents need no reset: HistCount gates every read.
    always_ff @(posedge clock) begin
        if (push)
            hist_mem[wr_ptr_reg] <= NumOut;
    end

endmodule

// File: tb/tb_calc_accumulator_core.sv
// Directed bench for calc_accumulator_core (WIDTH=8, HIST_DEPTH=4) with hand-computed results.
module tb_calc_accumulator_core;

    logic       clock = 1'b0;
    logic       Reset;
    logic [7:0] NumIn;
    logic [2:0] OpIn;
    logic       Enter;
    logic [7:0] NumOut;
    logic       Carry, Busy, Done, Err;
    logic [2:0] HistCount;

    int checks = 0;
    int errors = 0;
    int cnt;

    calc_accumulator_core #(.WIDTH(8), .HIST_DEPTH(4)) dut (
        .clock(clock), .Reset(Reset), .NumIn(NumIn), .OpIn(OpIn), .Enter(Enter),
        .NumOut(NumOut), .Carry(Carry), .Busy(Busy), .Done(Done), .Err(Err),
        .HistCount(HistCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command; returns at the falling edge after the accepting rising edge.
    task automatic cmd(input logic [2:0] op, input logic [7:0] b);
        @(negedge clock);
        NumIn = b;
        OpIn  = op;
        Enter = 1'b1;
        @(negedge clock);
        Enter = 1'b0;
        $display("op=%0d NumIn=%0d -> NumOut=%0d Carry=%0b Done=%0b Err=%0b HistCount=%0d",
                 op, b, NumOut, Carry, Done, Err, HistCount);
    endtask

    initial begin
        Reset = 1'b1;
        NumIn = '0;
        OpIn  = '0;
        Enter = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_numout", NumOut, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        chk("rst_hist", HistCount, 0);
        Reset = 1'b0;

        cmd(3'd0, 8'd200);
        chk("add200_num", NumOut, 200);
        chk("add200_carry", Carry, 0);
        chk("add200_done", Done, 1);
        cmd(3'd0, 8'd100);
        chk("add100_num", NumOut, 44);
        chk("add100_carry", Carry, 1);
        chk("add100_done", Done, 1);
        @(negedge clock);
        chk("done_pulse_end", Done, 0);

        cmd(3'd1, 8'd39);
        chk("sub39_num", NumOut, 5);
        chk("sub39_carry", Carry, 0);

        // Enter held high for 10 cycles must produce exactly one SUB
        @(negedge clock);
        NumIn = 8'd7;
        OpIn  = 3'd1;
        Enter = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            cnt += int'(Done);
        end
        Enter = 1'b0;
        $display("held SUB 7 -> NumOut=%0d Carry=%0b done_pulses=%0d", NumOut, Carry, cnt);
        chk("held_done_count", cnt, 1);
        chk("held_sub_num", NumOut, 254);
        chk("held_sub_carry", Carry, 1);
        chk("held_hist", HistCount, 4);

        cmd(3'd0, 8'd22);
        chk("add22_num", NumOut, 20);

        // MUL 20*13 = 260 with Enter pulses during Busy that must be dropped
        cmd(3'd6, 8'd13);
        NumIn = 8'd1;
        OpIn  = 3'd0;
        cnt = 0;
        while (Busy && cnt < 20) begin
            cnt++;
            if (cnt == 2 || cnt == 5) Enter = 1'b1;
            if (cnt == 3 || cnt == 6) Enter = 1'b0;
            if (cnt < 8) chk("mul_hold_num", NumOut, 20);
            @(negedge clock);
        end
        Enter = 1'b0;
        $display("MUL 13 -> busy_cycles=%0d NumOut=%0d Carry=%0b Done=%0b", cnt, NumOut, Carry, Done);
        chk("mul_busy_cycles", cnt, 8);
        chk("mul_num", NumOut, 4);
        chk("mul_carry", Carry, 1);
        chk("mul_done", Done, 1);
        chk("mul_done_not_busy", Busy, 0);
        repeat (3) @(negedge clock);
        chk("mul_no_queued_op", NumOut, 4);

        cmd(3'd4, 8'd0);
        chk("and0_num", NumOut, 0);
        for (int i = 1; i <= 5; i++) cmd(3'd0, 8'(i));
        chk("add15_num", NumOut, 15);
        chk("add15_hist", HistCount, 4);
        cmd(3'd7, 8'd0);
        chk("undo1_num", NumOut, 10);
        chk("undo1_done", Done, 1);
        chk("undo1_carry", Carry, 0);
        cmd(3'd7, 8'd0);
        chk("undo2_num", NumOut, 6);
        cmd(3'd7, 8'd0);
        chk("undo3_num", NumOut, 3);
        chk("undo3_hist", HistCount, 1);
        cmd(3'd7, 8'd0);
        chk("undo4_num", NumOut, 1);
        chk("undo4_hist", HistCount, 0);
        cmd(3'd7, 8'd0);
        chk("undo5_err", Err, 1);
        chk("undo5_done", Done, 0);
        chk("undo5_num", NumOut, 1);
        @(negedge clock);
        chk("err_pulse_end", Err, 0);

        cmd(3'd0, 8'd8);
        chk("add8_num", NumOut, 9);
        cmd(3'd3, 8'd9);
        chk("eq_true", NumOut, 1);
        cmd(3'd3, 8'd3);
        chk("eq_false", NumOut, 0);
        cmd(3'd5, 8'hFF);
        chk("xor_num", NumOut, 255);
        cmd(3'd4, 8'h3C);
        chk("and_num", NumOut, 8'h3C);
        cmd(3'd0, 8'hFF);
        chk("add_ff_num", NumOut, 8'h3B);
        chk("add_ff_carry", Carry, 1);
        cmd(3'd2, 8'h40);
        chk("or_num", NumOut, 8'h7B);
        chk("or_carry", Carry, 0);

        // Reset during the third MUL cycle aborts everything at once
        cmd(3'd6, 8'd3);
        chk("mul2_busy", Busy, 1);
        repeat (2) @(negedge clock);
        Reset = 1'b1;
        #1;
        chk("midrst_num", NumOut, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_hist", HistCount, 0);
        @(negedge clock);
        Reset = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            cnt += int'(Done) + int'(Busy);
        end
        $display("after mid-MUL reset -> NumOut=%0d done_or_busy_cycles=%0d", NumOut, cnt);
        chk("midrst_no_done", cnt, 0);
        chk("midrst_num_stays", NumOut, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
